// File: rtl/serial_cla_pkg.sv
// serial_cla_pkg: shared FSM state type and slice width for the serial CLA adder
package serial_cla_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/cla_slice4.sv
// cla_slice4: 4-bit generate/propagate carry-look-ahead adder slice
module cla_slice4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g, p;
    logic       c1, c2, c3;
    assign g  = x & y;
    assign p  = x ^ y;
    // every carry is a flat function of g/p/ci, no ripple chain
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
    assign s  = p ^ {c3, c2, c1, ci};
endmodule

// File: rtl/serial_cla_adder16.sv
// serial_cla_adder16: nibble-serial adder time-sharing one 4-bit CLA slice
// Optional signed-overflow output enabled by defining SERIAL_CLA_OVF_EN.
module serial_cla_adder16
    import serial_cla_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef SERIAL_CLA_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t               state;
    logic [IW-1:0]        idx;
    logic                 carry;
    logic [W-1:0]         a_r, b_r;
    logic [NIBBLE_W-1:0]  s;
    logic                 co;

    cla_slice4 u_slice (
        .x  (a_r[idx*NIBBLE_W +: NIBBLE_W]),
        .y  (b_r[idx*NIBBLE_W +: NIBBLE_W]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_CLA_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r   <= a;
                    b_r   <= b;
                    carry <= cin;
                    idx   <= '0;
                    sum   <= '0;
                    cout  <= 1'b0;
`ifdef SERIAL_CLA_OVF_EN
                    ovf   <= 1'b0;
`endif
                    state <= CALC;
                end
                CALC: begin
                    sum[idx*NIBBLE_W +: NIBBLE_W] <= s;
                    carry <= co;
                    idx   <= idx + 1'b1;
                    if (idx == IW'(NIBBLES - 1)) begin
                        cout  <= co;
`ifdef SERIAL_CLA_OVF_EN
                        ovf   <= (a_r[W-1] == b_r[W-1]) && (s[NIBBLE_W-1] != a_r[W-1]);
`endif
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_cla_adder16.sv
// tb_serial_cla_adder16: directed vectors checked against a cycle-level arithmetic model
// Build with SERIAL_CLA_OVF_EN defined to also check the ovf output.
module tb_serial_cla_adder16;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [W-1:0] a, b, sum;
`ifdef SERIAL_CLA_OVF_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_cla_adder16 #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_CLA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted operation becomes a result exactly N edges later,
    // then stays until the consumer takes it.
    logic         m_busy, m_done;
    int           m_cnt;
    logic [W:0]   m_exp;
    logic         m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else if (m_done) begin
            if (out_ready) m_done <= 1'b0;
        end else if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (in_valid) begin
            m_busy <= 1'b1;
            m_cnt  <= N;
            m_exp  <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            m_ovf  <= (a[W-1] == b[W-1]) && (((a + b + {{(W-1){1'b0}}, cin}) >> (W-1)) & 1) != a[W-1];
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("in_ready", in_ready, !(m_busy || m_done));
            chk("out_valid", out_valid, m_done);
            if (m_busy) chk("pending_nibbles_zero", sum >> (4 * (N - m_cnt)), 0);
            if (m_done) begin
                chk("sum", sum, m_exp[W-1:0]);
                chk("cout", cout, m_exp[W]);
`ifdef SERIAL_CLA_OVF_EN
                chk("ovf", ovf, m_ovf);
`endif
            end
        end
    end

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int hold,
                      input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        a = x; b = y; cin = c; in_valid = 1'b1;
        @(negedge clk);
        a = ~x; b = W'($urandom); cin = ~c;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, N);
        repeat (hold) begin
            chk("in_ready_done", in_ready, 1'b0);
            @(negedge clk);
            a = W'($urandom);
        end
        chk("lit_sum", sum, es);
        chk("lit_cout", cout, ec);
`ifdef SERIAL_CLA_OVF_EN
        chk("lit_ovf", ovf, eo);
`endif
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op(16'h0000, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
        op(16'hFFFF, 16'hFFFF, 1'b1, 0, 16'hFFFF, 1'b1, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
        op(16'h8000, 16'h8000, 1'b0, 1, 16'h0000, 1'b1, 1'b1);
        op(16'h1234, 16'h4321, 1'b0, 3, 16'h5555, 1'b0, 1'b0);

        // abort mid-operation while the third nibble is being processed
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_sum", sum, 0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_cout", cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        op(16'hA5A5, 16'h5A5A, 1'b1, 0, 16'h0000, 1'b1, 1'b0);
        op(16'h0F0F, 16'h00F1, 1'b1, 2, 16'h1001, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
